// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared constants and types for the snake game blocks.
//   SCORE_W       : score width in bits
//   MAX_SCORE     : score at which a game is won
//   score_t       : score value type
//   game_state_t  : game-flow state, shared by every block that follows the game
// -----------------------------------------------------------------------------
package snake_pkg;

    localparam int SCORE_W   = 7;
    localparam int MAX_SCORE = 50;

    typedef logic [SCORE_W-1:0] score_t;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        PAUSED,
        FLASH,
        HIGH
    } game_state_t;

endpackage

// File: rtl/score_display_ctrl_if.sv
// -----------------------------------------------------------------------------
// score_display_ctrl_if
// Bundle between the collision detectors / score tracker / display driver and
// the game-flow controller.
//   master modport : environment side (drives buttons, tick, collisions, score)
//   slave  modport : controller side
// Signals:
//   startBtn, tick, goodCollIn, badCollIn, trackerScore  -> into the controller
//   goodCollOut, badCollOut, gameActive, dispScore,
//   dispBlank, gameWon                                   <- from the controller
//   pauseBtn (only when SNAKE_PAUSE_EN is defined)       -> into the controller
// -----------------------------------------------------------------------------
interface score_display_ctrl_if #(
    parameter int SCORE_W = snake_pkg::SCORE_W
);

    logic               startBtn;
    logic               tick;
    logic               goodCollIn;
    logic               badCollIn;
    logic [SCORE_W-1:0] trackerScore;
`ifdef SNAKE_PAUSE_EN
    logic               pauseBtn;
`endif

    logic               goodCollOut;
    logic               badCollOut;
    logic               gameActive;
    logic [SCORE_W-1:0] dispScore;
    logic               dispBlank;
    logic               gameWon;

    modport master (
`ifdef SNAKE_PAUSE_EN
        output pauseBtn,
`endif
        output startBtn, tick, goodCollIn, badCollIn, trackerScore,
        input  goodCollOut, badCollOut, gameActive, dispScore, dispBlank, gameWon
    );

    modport slave (
`ifdef SNAKE_PAUSE_EN
        input  pauseBtn,
`endif
        input  startBtn, tick, goodCollIn, badCollIn, trackerScore,
        output goodCollOut, badCollOut, gameActive, dispScore, dispBlank, gameWon
    );

endinterface

// File: rtl/score_display_ctrl_flash_timer.sv
// -----------------------------------------------------------------------------
// flash_timer
// Counts tick strobes while enabled and toggles a blank flag on every counted
// tick. done flags the tick that completes FLASH_TICKS counts, so the owner can
// leave the flash phase on that same edge.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous clear of counter and blank (wins over tick)
//   tick     : slow enable strobe
//   enable   : count/toggle only while high
//   blank    : registered blank flag
//   done     : combinational, high on the final counted tick
// -----------------------------------------------------------------------------
module flash_timer #(
    parameter int FLASH_TICKS = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    input  logic enable,
    output logic blank,
    output logic done
);

    localparam int                CNT_W = $clog2(FLASH_TICKS + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(FLASH_TICKS - 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(FLASH_TICKS);

    logic [CNT_W-1:0] count;

    assign done = enable && tick && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            blank <= 1'b0;
        end else if (clear) begin
            count <= '0;
            blank <= 1'b0;
        end else if (enable && tick) begin
            blank <= ~blank;
            // Saturate: while paused the timer only drives the blink.
            if (count != FULL) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// -----------------------------------------------------------------------------
// score_display_ctrl
// Game-flow controller between the collision detectors / score tracker and the
// 7-segment display driver. Forwards collisions to the tracker only while a
// game runs, ends the game on a bad collision or on reaching MAX_SCORE,
// flashes the final score for FLASH_TICKS tick strobes, then hands the display
// back to the tracker (which then shows the high score).
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : score_display_ctrl_if.slave (buttons, tick, collisions, tracker
//          score in; gated collisions, gameActive, display value/blank,
//          gameWon out). All outputs are registered.
// Optional feature: define SNAKE_PAUSE_EN to add pauseBtn and the PAUSED state.
// -----------------------------------------------------------------------------
module score_display_ctrl #(
    parameter int MAX_SCORE   = snake_pkg::MAX_SCORE,
    parameter int FLASH_TICKS = 6,
    parameter int SCORE_W     = snake_pkg::SCORE_W
) (
    input  logic               clk,
    input  logic               rst,
    score_display_ctrl_if.slave bus
);

    import snake_pkg::*;

    if (FLASH_TICKS < 1) begin : g_flash_ticks_check
        $error("score_display_ctrl: FLASH_TICKS must be at least 1");
    end
    if (MAX_SCORE > 127 || MAX_SCORE >= (1 << SCORE_W)) begin : g_max_score_check
        $error("score_display_ctrl: MAX_SCORE must be <= 127 and fit in SCORE_W bits");
    end

    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(MAX_SCORE);

    game_state_t        state;
    game_state_t        next_state;
    logic [SCORE_W-1:0] latched_score;
    logic [SCORE_W-1:0] latched_next;
    logic [SCORE_W-1:0] disp_next;
    logic               good_next;
    logic               bad_next;
    logic               won_next;
    logic               active_next;
    logic               hit_bad;
    logic               hit_win;
    logic               timer_en;
    logic               timer_clear;
    logic               timer_blank;
    logic               timer_done;

    // A bad collision always beats the win condition in the same cycle.
    assign hit_bad = bus.badCollIn;
    assign hit_win = !bus.badCollIn && (bus.trackerScore >= WIN_SCORE);

    // The timer runs in FLASH (count + blink) and PAUSED (blink only); any
    // state change, including an abort or the final tick, clears it.
    assign timer_en    = (state == FLASH) || (state == PAUSED);
    assign timer_clear = !(timer_en && (next_state == state));

    flash_timer #(
        .FLASH_TICKS (FLASH_TICKS)
    ) u_flash_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .tick   (bus.tick),
        .enable (timer_en),
        .blank  (timer_blank),
        .done   (timer_done)
    );

    assign bus.dispBlank = timer_blank;

    // State register plus the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            latched_score   <= '0;
            bus.goodCollOut <= 1'b0;
            bus.badCollOut  <= 1'b0;
            bus.gameActive  <= 1'b0;
            bus.dispScore   <= '0;
            bus.gameWon     <= 1'b0;
        end else begin
            state           <= next_state;
            latched_score   <= latched_next;
            bus.goodCollOut <= good_next;
            bus.badCollOut  <= bad_next;
            bus.gameActive  <= active_next;
            bus.dispScore   <= disp_next;
            bus.gameWon     <= won_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns, otherwise a latch is inferred.
        next_state = state;
        unique case (state)
            IDLE: begin
                if (bus.startBtn) next_state = PLAY;
            end
            PLAY: begin
                if (hit_bad || hit_win) begin
                    next_state = FLASH;
                end
`ifdef SNAKE_PAUSE_EN
                else if (bus.pauseBtn) begin
                    next_state = PAUSED;
                end
`endif
            end
`ifdef SNAKE_PAUSE_EN
            PAUSED: begin
                if (bus.pauseBtn) next_state = PLAY;
            end
`endif
            FLASH: begin
                // startBtn outranks a simultaneous final tick.
                if (bus.startBtn)  next_state = PLAY;
                else if (timer_done) next_state = HIGH;
            end
            HIGH: begin
                if (bus.startBtn) next_state = PLAY;
            end
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        good_next    = 1'b0;
        bad_next     = 1'b0;
        latched_next = latched_score;
        won_next     = bus.gameWon;

        if (state == PLAY) begin
            if (hit_bad) begin
                bad_next     = 1'b1;
                latched_next = bus.trackerScore;
                won_next     = 1'b0;
            end else if (hit_win) begin
                // Winning cycle forwards nothing; the score is already final.
                latched_next = bus.trackerScore;
                won_next     = 1'b1;
            end else begin
                good_next    = bus.goodCollIn;
            end
        end

        // Every fresh game starts with gameWon cleared.
        if ((next_state == PLAY) && (state != PLAY) && (state != PAUSED)) begin
            won_next = 1'b0;
        end

        active_next = (next_state == PLAY) || (next_state == PAUSED);
        // While flashing, show the captured score, not the tracker, which may
        // already have been reset.
        disp_next   = (next_state == FLASH) ? latched_next : bus.trackerScore;
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_display_ctrl
// Directed bench for score_display_ctrl. Stimulus steps push the expected
// registered outputs into a queue tagged with the cycle they must appear in;
// a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_score_display_ctrl;

    localparam int SW = 7;

    typedef struct {
        int          cyc;
        string       name;
        logic [11:0] outs;   // {good, bad, active, disp[6:0], blank, won}
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle    = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    score_display_ctrl_if #(.SCORE_W(SW)) bus ();

    score_display_ctrl #(
        .MAX_SCORE   (50),
        .FLASH_TICKS (6),
        .SCORE_W     (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [11:0] pack(input logic g, input logic b, input logic a,
                                         input logic [SW-1:0] d, input logic bl, input logic w);
        return {g, b, a, d, bl, w};
    endfunction

    task automatic push_exp(input string nm, input int offset,
                            input logic g, input logic b, input logic a,
                            input logic [SW-1:0] d, input logic bl, input logic w);
        exp_t e;
        e.cyc  = cycle + offset;
        e.name = nm;
        e.outs = pack(g, b, a, d, bl, w);
        exp_q.push_back(e);
    endtask

    task automatic drive_step(input logic st, input logic tk, input logic gd, input logic bd,
                              input logic [SW-1:0] ts);
        @(posedge clk);
        #2;
        bus.startBtn     = st;
        bus.tick         = tk;
        bus.goodCollIn   = gd;
        bus.badCollIn    = bd;
        bus.trackerScore = ts;
`ifdef SNAKE_PAUSE_EN
        bus.pauseBtn     = 1'b0;
`endif
    endtask

    // One input cycle plus the outputs expected right after its sampling edge.
    task automatic step(input string nm,
                        input logic st, input logic tk, input logic gd, input logic bd,
                        input logic [SW-1:0] ts,
                        input logic g, input logic b, input logic a,
                        input logic [SW-1:0] d, input logic bl, input logic w);
        drive_step(st, tk, gd, bd, ts);
        push_exp(nm, 1, g, b, a, d, bl, w);
    endtask

`ifdef SNAKE_PAUSE_EN
    task automatic pause_step(input string nm, input logic gd, input logic [SW-1:0] ts,
                              input logic g, input logic a, input logic [SW-1:0] d,
                              input logic bl);
        drive_step(1'b0, 1'b0, gd, 1'b0, ts);
        bus.pauseBtn = 1'b1;
        push_exp(nm, 1, g, 1'b0, a, d, bl, 1'b0);
    endtask
`endif

    // Monitor: compare every expectation due in the current cycle.
    initial forever begin
        exp_t        e;
        logic [11:0] act;
        @(negedge clk);
        while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
            e   = exp_q.pop_front();
            act = {bus.goodCollOut, bus.badCollOut, bus.gameActive,
                   bus.dispScore, bus.dispBlank, bus.gameWon};
            n_checks++;
            if (e.cyc < cycle) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d was not checked in time (now %0d)",
                         e.name, e.cyc, cycle);
            end else if (act !== e.outs) begin
                n_fail++;
                $display("FAIL %s: got good=%b bad=%b act=%b disp=%0d blank=%b won=%b, expected good=%b bad=%b act=%b disp=%0d blank=%b won=%b",
                         e.name, act[11], act[10], act[9], act[8:2], act[1], act[0],
                         e.outs[11], e.outs[10], e.outs[9], e.outs[8:2], e.outs[1], e.outs[0]);
            end
        end
    end

    initial begin
        bus.startBtn     = 1'b0;
        bus.tick         = 1'b0;
        bus.goodCollIn   = 1'b0;
        bus.badCollIn    = 1'b0;
        bus.trackerScore = '0;
`ifdef SNAKE_PAUSE_EN
        bus.pauseBtn     = 1'b0;
`endif

        // Reset holds every output at zero even with a nonzero tracker score.
        //    name          st tk gd bd ts   good bad act disp blank won
        step("reset",       0, 0, 0, 0, 5,   0,   0,  0,  0,   0,    0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // 1: start, forwarding latency, display tracking.
        step("idle_disp",   0, 0, 0, 0, 5,   0,   0,  0,  5,   0,    0);
        step("start",       1, 0, 0, 0, 5,   0,   0,  1,  5,   0,    0);
        step("play_good",   0, 0, 1, 0, 5,   1,   0,  1,  5,   0,    0);
        step("good_end",    0, 0, 0, 0, 6,   0,   0,  1,  6,   0,    0);
        step("start_ign",   1, 0, 0, 0, 6,   0,   0,  1,  6,   0,    0);

        // 2: simultaneous collisions, bad wins; flash 12 for six ticks.
        step("both_coll",   0, 0, 1, 1, 12,  0,   1,  0,  12,  0,    0);
        step("flash_hold",  0, 0, 1, 1, 0,   0,   0,  0,  12,  0,    0);
        step("flash_t1",    0, 1, 0, 0, 0,   0,   0,  0,  12,  1,    0);
        step("flash_notk",  0, 0, 0, 0, 0,   0,   0,  0,  12,  1,    0);
        step("flash_t2",    0, 1, 0, 0, 0,   0,   0,  0,  12,  0,    0);
        step("flash_t3",    0, 1, 0, 0, 0,   0,   0,  0,  12,  1,    0);
        step("flash_t4",    0, 1, 0, 0, 0,   0,   0,  0,  12,  0,    0);
        step("flash_t5",    0, 1, 0, 0, 0,   0,   0,  0,  12,  1,    0);
        step("flash_t6",    0, 1, 0, 0, 33,  0,   0,  0,  33,  0,    0);
        step("high_coll",   0, 1, 1, 1, 33,  0,   0,  0,  33,  0,    0);

        // 3: win at MAX_SCORE, nothing forwarded, gameWon until next start.
        step("high_start",  1, 0, 0, 0, 0,   0,   0,  1,  0,   0,    0);
        step("win",         0, 0, 1, 0, 50,  0,   0,  0,  50,  0,    1);
        step("win_t1",      0, 1, 0, 0, 0,   0,   0,  0,  50,  1,    1);
        step("win_t2",      0, 1, 0, 0, 0,   0,   0,  0,  50,  0,    1);
        step("win_t3",      0, 1, 0, 0, 0,   0,   0,  0,  50,  1,    1);
        step("win_t4",      0, 1, 0, 0, 0,   0,   0,  0,  50,  0,    1);
        step("win_t5",      0, 1, 0, 0, 0,   0,   0,  0,  50,  1,    1);
        step("win_t6",      0, 1, 0, 0, 50,  0,   0,  0,  50,  0,    1);
        step("won_clear",   1, 0, 0, 0, 0,   0,   0,  1,  0,   0,    0);

        // 4: start together with a tick after two ticks aborts the flash.
        step("to_flash2",   0, 0, 0, 1, 7,   0,   1,  0,  7,   0,    0);
        step("ab_t1",       0, 1, 0, 0, 0,   0,   0,  0,  7,   1,    0);
        step("ab_t2",       0, 1, 0, 0, 0,   0,   0,  0,  7,   0,    0);
        step("abort",       1, 1, 0, 0, 0,   0,   0,  1,  0,   0,    0);
        step("post_abort",  0, 1, 0, 0, 0,   0,   0,  1,  0,   0,    0);
        step("abort_good",  0, 0, 1, 0, 0,   1,   0,  1,  0,   0,    0);

        // 5: asynchronous reset in the middle of a flash.
        step("to_flash3",   0, 0, 0, 1, 9,   0,   1,  0,  9,   0,    0);
        step("rs_t1",       0, 1, 0, 0, 9,   0,   0,  0,  9,   1,    0);
        drive_step(0, 0, 0, 0, 9);
        @(posedge clk);
        #2;
        rst            = 1'b1;
        bus.goodCollIn = 1'b1;
        bus.badCollIn  = 1'b1;
        push_exp("rst_async", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        push_exp("rst_hold",  0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step("idle_coll",   0, 0, 1, 1, 4,   0,   0,  0,  4,   0,    0);

`ifdef SNAKE_PAUSE_EN
        // 6: pause drops collisions, blinks on tick, resume forwards again.
        step("p_start",     1, 0, 0, 0, 3,   0,   0,  1,  3,   0,    0);
        pause_step("p_pause",  0, 3,          0,          1,  3,   0);
        step("p_good",      0, 0, 1, 0, 3,   0,   0,  1,  3,   0,    0);
        step("p_start_ign", 1, 0, 0, 0, 3,   0,   0,  1,  3,   0,    0);
        step("p_tick",      0, 1, 0, 0, 3,   0,   0,  1,  3,   1,    0);
        pause_step("p_resume", 0, 3,          0,          1,  3,   0);
        step("p_good2",     0, 0, 1, 0, 3,   1,   0,  1,  3,   0,    0);
`endif

        drive_step(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                     e.name, e.cyc, cycle);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Game-flow controller that sequences the score tracker.
- Gates collision pulses from the collision detectors into the tracker, and only while a game is running.
- Detects end of game: a bad collision or the win score.
- Captures the final score and shows it flashing on the display for a fixed number of ticks, then hands the display back to the tracker's high-score output.
- Sits between the collision detectors / tracker and the 7-seg display driver.

Parameters:
- MAX_SCORE, 50, score at which the game is won; must be ≤127.
- FLASH_TICKS, 6, number of tick strobes the final score flashes; must be ≥1 (elaboration-time check).
- SCORE_W, 7, score width in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- startBtn  in  1  single-cycle start pulse, already synchronized and debounced.
- tick  in  1  single-cycle slow enable strobe (flash rate).
- goodCollIn  in  1  food collision from the detector.
- badCollIn  in  1  wall/self collision from the detector.
- trackerScore  in  SCORE_W  tracker's displayed score: current score in play, high score after game end.
- goodCollOut  out  1  gated good collision to the tracker.
- badCollOut  out  1  gated bad collision to the tracker.
- gameActive  out  1  high while state is PLAY (or PAUSED).
- dispScore  out  SCORE_W  value to the display driver.
- dispBlank  out  1  display blank, for flashing.
- gameWon  out  1  last game ended by reaching MAX_SCORE.

Behaviour:
- Reset:
  - All outputs are registered; rst clears state asynchronously.
  - State=IDLE, latchedScore=0, flash counter=0, all outputs 0.
  - rst asserted mid-game or mid-flash returns to IDLE at once, with no pulses emitted.
- States: IDLE, PLAY, FLASH, HIGH, plus PAUSED with the optional feature. One-hot or binary encoding, implementer's choice.
- IDLE:
  - dispScore=trackerScore, dispBlank=0.
  - startBtn → PLAY. gameActive=1 from the next cycle.
- PLAY, collision forwarding:
  - Latency 1 cycle.
  - goodCollOut = goodCollIn & ~badCollIn.
  - badCollOut = badCollIn.
  - When both arrive in the same cycle, the bad collision wins and the good one is dropped.
- PLAY, display: dispScore=trackerScore.
- PLAY, bad-collision end:
  - badCollIn=1 → latchedScore ≤ trackerScore, sampled in the same cycle (pre-reset value); gameWon ≤ 0; go to FLASH.
- PLAY, win end:
  - trackerScore ≥ MAX_SCORE and no badCollIn → latchedScore ≤ trackerScore, gameWon ≤ 1, go to FLASH.
  - No collision pulse is forwarded in that cycle.
- PLAY, other inputs: startBtn is ignored.
- FLASH, entry:
  - gameActive=0, dispScore=latchedScore, dispBlank=0 on entry, flash counter=0.
- FLASH, per tick:
  - dispBlank toggles; counter increments.
  - When the counter reaches FLASH_TICKS, go to HIGH with dispBlank=0 on the same edge.
- FLASH, other inputs:
  - startBtn → PLAY immediately (flash aborted, dispBlank=0, gameWon cleared).
  - Collision inputs are ignored and never forwarded.
- HIGH:
  - dispScore=trackerScore (tracker shows high score), dispBlank=0.
  - startBtn → PLAY and clears gameWon.
  - Collisions are ignored.
- tick outside FLASH: ignored.
- startBtn and tick in the same FLASH cycle: startBtn has priority.
- Width: comparisons are unsigned on SCORE_W bits. The counter is $clog2(FLASH_TICKS+1) bits, with no wrap possible.

Optional Feature:
- Macro: SNAKE_PAUSE_EN.
- With the macro defined:
  - Adds port pauseBtn (in, 1, single-cycle pulse) and state PAUSED.
  - pauseBtn in PLAY → PAUSED; pauseBtn in PAUSED → PLAY.
  - In PAUSED: gameActive stays 1, collisions are dropped (not queued), dispScore=trackerScore, dispBlank follows tick toggling.
  - startBtn in PAUSED is ignored.
  - pauseBtn in any other state is ignored.
- Without the macro: no pauseBtn port and no PAUSED state; behaviour as above.

Decomposition:
- Shared package snake_pkg:
  - SCORE_W and MAX_SCORE constants.
  - Typedef score_t (logic [SCORE_W-1:0]).
  - Enum game_state_t {IDLE, PLAY, PAUSED, FLASH, HIGH}, shared with other game blocks.
- One natural sub-module, flash_timer: tick counter plus blank toggle, with inputs clear, tick, enable and outputs blank, done. Instantiated once.

Test Plan:
1. Reset then startBtn → gameActive=1 the next cycle; goodCollIn pulse → goodCollOut pulse exactly 1 cycle later; dispScore tracks trackerScore.
2. PLAY with trackerScore=12, goodCollIn=badCollIn=1 in the same cycle → only badCollOut=1; FLASH is entered; dispScore holds 12 while trackerScore drops to 0; dispBlank toggles on each of 6 ticks; HIGH after the 6th tick with dispBlank=0.
3. Drive trackerScore=50 in PLAY → gameWon=1, FLASH shows 50, no collision pulses; a later startBtn in HIGH clears gameWon.
4. startBtn together with tick in FLASH after 2 ticks → PLAY next cycle, dispBlank=0, no further toggles.
5. Assert rst mid-FLASH → IDLE immediately, all outputs 0; collisions in IDLE, FLASH and HIGH are never forwarded.
6. With SNAKE_PAUSE_EN: pauseBtn in PLAY, then goodCollIn → no goodCollOut; second pauseBtn → PLAY; next goodCollIn is forwarded.
